// File: rtl/avalon_debounced_button_pio.sv
// Avalon-MM input PIO for buttons/switches: per-bit 2-FF synchroniser, debounce filter,
// selectable rising/falling edge capture with write-1-to-clear and a masked level IRQ.
module avalon_debounced_button_pio #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_RISE_EN   = '0,
  parameter logic [WIDTH-1:0] RESET_FALL_EN   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [WIDTH-1:0] sync1_q, sync_q;
  logic [WIDTH-1:0] deb_q, deb_d, deb_dly_q;
  logic [WIDTH-1:0] irq_mask_q, rise_en_q, fall_en_q;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d, edge_det, cap_clr;
  logic [WIDTH-1:0] wdata;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q;
  logic             wr_en, wr_mask, wr_cap, wr_rise, wr_fall;
  logic             unused_writedata;

  assign wdata            = writedata[WIDTH-1:0];
  assign unused_writedata = ^writedata;

  assign wr_en   = chipselect && !write_n;
  assign wr_mask = wr_en && (address == 3'd2);
  assign wr_cap  = wr_en && (address == 3'd3);
  assign wr_rise = wr_en && (address == 3'd4);
  assign wr_fall = wr_en && (address == 3'd5);

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb_d = sync_q;
  end else begin : g_filter
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] cnt_q [WIDTH];
    logic [CntW-1:0] cnt_d [WIDTH];

    // Counter runs only while sync disagrees with the filtered value.
    always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
        if (sync_q[i] != deb_q[i]) begin
          if (cnt_q[i] == CntLast) begin
            deb_d[i] = sync_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (reset) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_d[i];
        end
      end
    end
  end

  assign edge_det = (rise_en_q & deb_q & ~deb_dly_q) | (fall_en_q & ~deb_q & deb_dly_q);
  assign cap_clr  = wr_cap ? wdata : '0;
  // A fresh edge overrides a same-cycle clear so no event is lost.
  assign edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;

  always_comb begin
    readdata_d = '0;
    case (address)
      3'd0:    readdata_d[WIDTH-1:0] = deb_q;
      3'd1:    readdata_d[WIDTH-1:0] = sync_q;
      3'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      3'd3:    readdata_d[WIDTH-1:0] = edge_cap_q;
      3'd4:    readdata_d[WIDTH-1:0] = rise_en_q;
      3'd5:    readdata_d[WIDTH-1:0] = fall_en_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      rise_en_q  <= RESET_RISE_EN;
      fall_en_q  <= RESET_FALL_EN;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= in_port;
      sync_q     <= sync1_q;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_q;
      edge_cap_q <= edge_cap_d;
      if (wr_mask) irq_mask_q <= wdata;
      if (wr_rise) rise_en_q <= wdata;
      if (wr_fall) fall_en_q <= wdata;
      readdata_q <= readdata_d;
      irq_q      <= |(edge_cap_q & irq_mask_q);
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
